// File: rtl/stripe_sequencer_if.sv
// Bus bundle between stripe_sequencer and its gene memories, PE array and result consumer.
// master = sequencer side, slave = environment side.
interface stripe_sequencer_if #(
  parameter int unsigned SEQ_LEN    = 1024,
  parameter int unsigned PE_NUM     = 64,
  parameter int unsigned NUM_STRIPE = 16,
  parameter int unsigned SCORE_W    = 14
);
  localparam int unsigned AW = $clog2(SEQ_LEN);
  localparam int unsigned SW = $clog2(NUM_STRIPE);

  logic                  i_go;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;
  logic [AW-1:0]         o_a_addr;
  logic [1:0]            i_a_data;
  logic [SW-1:0]         o_b_addr;
  logic [2*PE_NUM-1:0]   i_b_data;
  logic                  o_pe_start;
  logic [1:0]            o_pe_A;
  logic [2*PE_NUM-1:0]   o_pe_B;
  logic                  i_stripe_end;
  logic [AW-1:0]         i_start_pos;
  logic [AW-1:0]         i_end_pos;
  logic [SCORE_W-1:0]    i_max_score;
  logic                  o_res_valid;
  logic                  i_res_ready;
  logic [SW-1:0]         o_res_stripe;
  logic [AW-1:0]         o_res_start;
  logic [AW:0]           o_res_end;
  logic [SCORE_W-1:0]    o_res_max;

  modport master (
    input  i_go, i_a_data, i_b_data, i_stripe_end, i_start_pos, i_end_pos, i_max_score, i_res_ready,
    output o_busy, o_done, o_error, o_a_addr, o_b_addr, o_pe_start, o_pe_A, o_pe_B,
           o_res_valid, o_res_stripe, o_res_start, o_res_end, o_res_max
  );

  modport slave (
    output i_go, i_a_data, i_b_data, i_stripe_end, i_start_pos, i_end_pos, i_max_score, i_res_ready,
    input  o_busy, o_done, o_error, o_a_addr, o_b_addr, o_pe_start, o_pe_A, o_pe_B,
           o_res_valid, o_res_stripe, o_res_start, o_res_end, o_res_max
  );
endinterface

// File: rtl/stripe_sequencer.sv
// Drives a banded alignment run through the PE array stripe by stripe: loads B word, streams A,
// waits for stripe-end, publishes the stripe result and advances the running start position.
module stripe_sequencer #(
  parameter int unsigned SEQ_LEN    = 1024,
  parameter int unsigned PE_NUM     = 64,
  parameter int unsigned NUM_STRIPE = 16,
  parameter int unsigned SCORE_W    = 14,
  parameter int unsigned DRAIN_MAX  = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  stripe_sequencer_if.master  bus
);
  localparam int unsigned AW = $clog2(SEQ_LEN);
  localparam int unsigned SW = $clog2(NUM_STRIPE);
  localparam int unsigned BW = 2 * PE_NUM;
  localparam int unsigned CW = $clog2(DRAIN_MAX + 1);

  localparam logic [AW-1:0] LAST_ADDR   = AW'(SEQ_LEN - 1);
  localparam logic [AW:0]   LAST_SUM    = (AW+1)'(SEQ_LEN - 1);
  localparam logic [SW-1:0] LAST_STRIPE = SW'(NUM_STRIPE - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOADB, S_WAITB, S_STREAM, S_DRAIN, S_REPORT, S_DONE
  } state_t;

  state_t              state;
  logic [AW-1:0]       start_reg;
  logic [AW-1:0]       ptr;
  logic [AW-1:0]       spos_q;
  logic [SW-1:0]       stripe;
  logic [BW-1:0]       b_q;
  logic [CW-1:0]       drain_cnt;
  logic                a_vld_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic                res_valid_q;
  logic [AW:0]         res_end_q;
  logic [SCORE_W-1:0]  res_max_q;
  logic                stripe_end_act;
  logic [AW:0]         next_start;

  assign stripe_end_act = bus.i_stripe_end && (state == S_STREAM || state == S_DRAIN);
  assign next_start     = {1'b0, start_reg} + {1'b0, spos_q};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= S_IDLE;
      start_reg   <= '0;
      ptr         <= '0;
      spos_q      <= '0;
      stripe      <= '0;
      b_q         <= '0;
      drain_cnt   <= '0;
      a_vld_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_end_q   <= '0;
      res_max_q   <= '0;
    end else begin
      done_q <= 1'b0;
      // Stripe-end wins over streaming/drain bookkeeping; the read still in flight is dropped.
      if (stripe_end_act) begin
        spos_q      <= bus.i_start_pos;
        res_end_q   <= {1'b0, bus.i_end_pos} + {1'b0, start_reg};
        res_max_q   <= bus.i_max_score;
        a_vld_q     <= 1'b0;
        res_valid_q <= 1'b1;
        state       <= S_REPORT;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.i_go) begin
              busy_q    <= 1'b1;
              error_q   <= 1'b0;
              stripe    <= '0;
              start_reg <= '0;
              state     <= S_LOADB;
            end
          end
          S_LOADB: state <= S_WAITB;
          S_WAITB: begin
            b_q   <= bus.i_b_data;
            ptr   <= start_reg;
            state <= S_STREAM;
          end
          S_STREAM: begin
            a_vld_q <= 1'b1;
            if (ptr == LAST_ADDR) begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
          // The base read at the last address lands in the first drain cycle; a_vld_q delivers it.
          S_DRAIN: begin
            a_vld_q <= 1'b0;
            if (drain_cnt == DRAIN_LAST) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state   <= S_DONE;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
          S_REPORT: begin
            if (bus.i_res_ready) begin
              res_valid_q <= 1'b0;
              start_reg   <= (next_start > LAST_SUM) ? LAST_ADDR : next_start[AW-1:0];
              if (stripe == LAST_STRIPE) begin
                done_q <= 1'b1;
                state  <= S_DONE;
              end else begin
                stripe <= stripe + 1'b1;
                state  <= S_LOADB;
              end
            end
          end
          S_DONE: begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_error      = error_q;
  assign bus.o_a_addr     = ptr;
  assign bus.o_b_addr     = stripe;
  assign bus.o_pe_start   = a_vld_q && !stripe_end_act;
  assign bus.o_pe_A       = (a_vld_q && !stripe_end_act) ? bus.i_a_data : '0;
  assign bus.o_pe_B       = b_q;
  assign bus.o_res_valid  = res_valid_q;
  assign bus.o_res_stripe = stripe;
  assign bus.o_res_start  = start_reg;
  assign bus.o_res_end    = res_end_q;
  assign bus.o_res_max    = res_max_q;
endmodule

// File: tb/tb_stripe_sequencer.sv
// Bench for stripe_sequencer: memory models, a scripted stub PE array and a result scoreboard.
module tb_stripe_sequencer;
  localparam int SEQ_LEN    = 1024;
  localparam int PE_NUM     = 64;
  localparam int NUM_STRIPE = 16;
  localparam int SCORE_W    = 14;
  localparam int DRAIN_MAX  = 1024;

  localparam int M_AFTER = 0;  // stripe-end N cycles after the last base
  localparam int M_AT    = 1;  // stripe-end while streaming at address N
  localparam int M_NEVER = 2;  // stripe-end never comes

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int stripe;
    int start;
    int endp;
    int mx;
  } res_t;
  res_t sb[$];

  logic [1:0]          amem [SEQ_LEN];
  logic [2*PE_NUM-1:0] bmem [NUM_STRIPE];

  stripe_sequencer_if #(.SEQ_LEN(SEQ_LEN), .PE_NUM(PE_NUM), .NUM_STRIPE(NUM_STRIPE),
                        .SCORE_W(SCORE_W)) bus ();

  stripe_sequencer #(.SEQ_LEN(SEQ_LEN), .PE_NUM(PE_NUM), .NUM_STRIPE(NUM_STRIPE),
                     .SCORE_W(SCORE_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.i_a_data <= amem[bus.o_a_addr];
    bus.i_b_data <= bmem[bus.o_b_addr];
  end

  logic [187:0] outs;
  assign outs = {bus.o_busy, bus.o_done, bus.o_error, bus.o_a_addr, bus.o_b_addr, bus.o_pe_start,
                 bus.o_pe_A, bus.o_pe_B, bus.o_res_valid, bus.o_res_stripe, bus.o_res_start,
                 bus.o_res_end, bus.o_res_max};

  task automatic go_pulse();
    @(negedge clk);
    bus.i_go = 1'b1;
    @(negedge clk);
    bus.i_go = 1'b0;
  endtask

  // Runs one stripe against the stub PE; returns the next start position the model expects.
  task automatic do_stripe(input int stripe, input int start, input int mode, input int param,
                           input int spos, input int epos, input int mx, input int hold,
                           input bit check_lat, output int next_start);
    int w, k, n, d, cyc, bad, extra, sbad;
    bit ended, saw_valid;
    int prev_addr;
    res_t e;
    next_start = (start + spos > SEQ_LEN - 1) ? SEQ_LEN - 1 : start + spos;
    n = SEQ_LEN - start;

    w = 0;
    prev_addr = -1;
    while (!bus.o_pe_start && w < 20) begin
      prev_addr = int'(bus.o_a_addr);
      @(negedge clk);
      w++;
    end
    checks++;
    if (!bus.o_pe_start) begin
      errors++;
      $display("FAIL first_base s%0d: no o_pe_start after %0d cycles, required within 20", stripe, w);
      return;
    end
    if (check_lat) begin
      checks++;
      if (w !== 3) begin
        errors++;
        $display("FAIL go_latency: first base %0d cycles after go, required 4", w + 1);
      end
    end
    checks++;
    if (prev_addr !== start || bus.o_b_addr !== 4'(stripe)) begin
      errors++;
      $display("FAIL first_addr s%0d: a_addr %0d b_addr %0d, required %0d %0d",
               stripe, prev_addr, bus.o_b_addr, start, stripe);
    end

    k = 0; d = 0; cyc = 0; bad = 0; ended = 1'b0; saw_valid = 1'b0;
    while (!ended && cyc < SEQ_LEN + DRAIN_MAX + 64) begin
      if (bus.o_res_valid) saw_valid = 1'b1;
      if (mode == M_AT && bus.o_pe_start && int'(bus.o_a_addr) == param) begin
        bus.i_start_pos  = 10'(spos);
        bus.i_end_pos    = 10'(epos);
        bus.i_max_score  = 14'(mx);
        bus.i_stripe_end = 1'b1;
        sb.push_back('{stripe, start, epos + start, mx});
        #1;
        checks++;
        if (bus.o_pe_start !== 1'b0 || bus.o_pe_A !== 2'b00) begin
          errors++;
          $display("FAIL end_forces_idle s%0d: pe_start %b pe_A %b, required 0 0",
                   stripe, bus.o_pe_start, bus.o_pe_A);
        end
        ended = 1'b1;
      end else begin
        if (bus.o_pe_start) begin
          if (start + k >= SEQ_LEN || bus.o_pe_A !== amem[start + k] || bus.o_pe_B !== bmem[stripe])
            bad++;
          k++;
        end else if (k == n) begin
          d++;
        end
        if (mode == M_AFTER && k == n && d == param) begin
          bus.i_start_pos  = 10'(spos);
          bus.i_end_pos    = 10'(epos);
          bus.i_max_score  = 14'(mx);
          bus.i_stripe_end = 1'b1;
          sb.push_back('{stripe, start, epos + start, mx});
          ended = 1'b1;
        end
        if (mode == M_NEVER && bus.o_done) ended = 1'b1;
      end
      if (!ended) begin
        @(negedge clk);
        cyc++;
      end
    end

    checks++;
    if (!ended) begin
      errors++;
      $display("FAIL stripe_end s%0d: scenario did not complete in %0d cycles", stripe, cyc);
      return;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL base_data s%0d: %0d wrong A/B values, required 0", stripe, bad);
    end
    checks++;
    if (k !== ((mode == M_AT) ? param - 1 - start : n)) begin
      errors++;
      $display("FAIL base_count s%0d: %0d bases, required %0d",
               stripe, k, (mode == M_AT) ? param - 1 - start : n);
    end

    if (mode == M_NEVER) begin
      checks++;
      if (d !== DRAIN_MAX || bus.o_error !== 1'b1 || saw_valid) begin
        errors++;
        $display("FAIL timeout: drain %0d error %b result_seen %b, required %0d 1 0",
                 d, bus.o_error, saw_valid, DRAIN_MAX);
      end
      next_start = start;
      return;
    end

    @(negedge clk);
    bus.i_stripe_end = 1'b0;
    bus.i_start_pos  = 10'($urandom);
    bus.i_end_pos    = 10'($urandom);
    bus.i_max_score  = 14'($urandom);
    w = 0; extra = 0;
    while (!bus.o_res_valid && w < 4) begin
      if (bus.o_pe_start) extra++;
      @(negedge clk);
      w++;
    end
    checks++;
    if (!bus.o_res_valid || w !== 0 || extra !== 0 || bus.o_pe_start !== 1'b0) begin
      errors++;
      $display("FAIL res_valid s%0d: valid %b after %0d cycles, extra bases %0d, required 1 0 0",
               stripe, bus.o_res_valid, w, extra);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard s%0d: result with nothing expected", stripe);
      return;
    end
    e = sb.pop_front();
    if (bus.o_res_stripe !== 4'(e.stripe) || bus.o_res_start !== 10'(e.start) ||
        bus.o_res_end !== 11'(e.endp) || bus.o_res_max !== 14'(e.mx)) begin
      errors++;
      $display("FAIL result s%0d: got {%0d,%0d,%0d,%0d} required {%0d,%0d,%0d,%0d}", stripe,
               bus.o_res_stripe, bus.o_res_start, bus.o_res_end, bus.o_res_max,
               e.stripe, e.start, e.endp & 11'h7ff, e.mx);
    end

    sbad = 0;
    for (int h = 0; h < hold; h++) begin
      if (!bus.o_res_valid || bus.o_pe_start || bus.o_b_addr !== 4'(e.stripe) ||
          bus.o_res_stripe !== 4'(e.stripe) || bus.o_res_start !== 10'(e.start) ||
          bus.o_res_end !== 11'(e.endp) || bus.o_res_max !== 14'(e.mx))
        sbad++;
      bus.i_stripe_end = (h == 3);
      bus.i_go         = (h == 3);
      @(negedge clk);
    end
    bus.i_stripe_end = 1'b0;
    bus.i_go         = 1'b0;
    if (hold > 0) begin
      checks++;
      if (sbad !== 0) begin
        errors++;
        $display("FAIL res_hold s%0d: %0d unstable cycles, required 0", stripe, sbad);
      end
    end

    bus.i_res_ready = 1'b1;
    @(negedge clk);
    bus.i_res_ready = 1'b0;
    checks++;
    if (bus.o_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake s%0d: o_res_valid %b after transfer, required 0", stripe, bus.o_res_valid);
    end
  endtask

  task automatic test_reset();
    bus.i_go = 1'b0; bus.i_stripe_end = 1'b0; bus.i_res_ready = 1'b0;
    bus.i_start_pos = '0; bus.i_end_pos = '0; bus.i_max_score = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: %h, required 0", outs);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL idle_outputs: %h, required 0", outs);
    end
  endtask

  task automatic test_reset_mid_stream();
    int st, nxt, w, bad;
    go_pulse();
    st = 0;
    for (int s = 0; s < 3; s++) begin
      do_stripe(s, st, M_AT, st + 6, 10, 50 + s, 20 + s, 0, 1'b0, nxt);
      st = nxt;
    end
    w = 0;
    while (!bus.o_pe_start && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!bus.o_pe_start || bus.o_b_addr !== 4'd3) begin
      errors++;
      $display("FAIL mid_stream_reach: pe_start %b b_addr %0d, required 1 3", bus.o_pe_start, bus.o_b_addr);
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_abort: %h, required 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_done || bus.o_busy || bus.o_pe_start) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_no_done: %0d cycles with done/busy/pe_start, required 0", bad);
    end
    sb.delete();
    go_pulse();
    do_stripe(0, 0, M_AT, 4, 3, 11, 7, 0, 1'b1, nxt);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_run();
    int st, nxt, pulses;
    go_pulse();
    do_stripe(0, 0, M_AFTER, 200, 40, 900, 500, 0, 1'b1, nxt);
    do_stripe(1, nxt, M_AT, 300, 960, 600, 1234, 0, 1'b0, nxt);
    do_stripe(2, nxt, M_AFTER, 3, 100, 1023, 16383, 0, 1'b0, nxt);
    checks++;
    if (nxt !== 1023 || bus.o_res_start !== 10'd1023) begin
      errors++;
      $display("FAIL clamp: start_reg %0d, required 1023", bus.o_res_start);
    end
    st = nxt;
    for (int s = 3; s < NUM_STRIPE; s++) begin
      do_stripe(s, st, M_AFTER, 2, s, s * 7, s * 100, (s == 4) ? 10 : 0, 1'b0, nxt);
      st = nxt;
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.o_done) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1 || bus.o_busy !== 1'b0 || bus.o_error !== 1'b0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL run_done: pulses %0d busy %b error %b pending %0d, required 1 0 0 0",
               pulses, bus.o_busy, bus.o_error, sb.size());
    end
  endtask

  task automatic test_timeout();
    int nxt;
    go_pulse();
    do_stripe(0, 0, M_NEVER, 0, 0, 0, 0, 0, 1'b0, nxt);
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_done: done %b busy %b, required 1 1", bus.o_done, bus.o_busy);
    end
    @(negedge clk);
    checks++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_idle: done %b busy %b error %b, required 0 0 1",
               bus.o_done, bus.o_busy, bus.o_error);
    end
    go_pulse();
    checks++;
    if (bus.o_error !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL error_clear: error %b busy %b, required 0 1", bus.o_error, bus.o_busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < SEQ_LEN; i++) amem[i] = 2'($urandom);
    for (int i = 0; i < NUM_STRIPE; i++) bmem[i] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_reset_mid_stream();
    test_full_run();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
